// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between a CPU data port and dmem_responder.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once the responder raises rsp_valid it keeps rsp_valid,
// rsp_rdata and rsp_err stable until the edge where rsp_ready is seen high.
// The responder never queues: req_valid seen while req_ready=0 is dropped.
//
// Signals:
//   req_valid / req_ready  request handshake (CPU -> responder)
//   req_we                 1 = store, 0 = load
//   req_addr               32-bit byte address
//   req_wdata              32-bit store data
//   req_be                 byte enables, bit0 = data[7:0] (DMEM_BYTE_WRITE_EN)
//   rsp_valid / rsp_ready  response handshake (responder -> CPU)
//   rsp_rdata              load data, 0 for stores and errors
//   rsp_err                misaligned or out-of-range access
//
// Macro: DMEM_BYTE_WRITE_EN adds req_be.
// Modports: master = CPU side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
`ifdef DMEM_BYTE_WRITE_EN
    output req_be,
`endif
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
`ifdef DMEM_BYTE_WRITE_EN
    input  req_be,
`endif
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data memory responder with programmable wait states.
// A request is captured in IDLE, waits WAIT_CYCLES cycles, executes against
// an internal 2**DEPTH_LOG2 x 32-bit word array, then holds the response in
// RESP until the CPU takes it.
//
// Parameters:
//   DEPTH_LOG2   word-address width (default 6 -> 64 words)
//   WAIT_CYCLES  wait states between accept and memory access (0..15)
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset (memory contents are kept)
//   bus        dmem_responder_if.slave request/response bus
//   state_dbg  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Macro: DMEM_BYTE_WRITE_EN enables per-byte store enables via bus.req_be.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Access actually performed this cycle (either from the captured
  // registers, or straight from the bus when there are no wait states).
  logic                  exec;
  logic                  exec_we;
  logic [31:0]           exec_addr;
  logic [31:0]           exec_wdata;
  logic [3:0]            exec_be;
  logic                  exec_err;
  logic [DEPTH_LOG2-1:0] exec_idx;
  logic                  wr_en;
  logic [3:0]            in_be;

`ifdef DMEM_BYTE_WRITE_EN
  assign in_be = bus.req_be;
`else
  assign in_be = 4'hF;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    exec       = 1'b0;
    exec_we    = we_q;
    exec_addr  = addr_q;
    exec_wdata = wdata_q;
    exec_be    = be_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = in_be;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the accepting edge is also the executing edge.
            exec       = 1'b1;
            exec_we    = bus.req_we;
            exec_addr  = bus.req_addr;
            exec_wdata = bus.req_wdata;
            exec_be    = in_be;
            state_d    = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          exec    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Out of range means any address bit above the word index is set.
    exec_err = (exec_addr[1:0] != 2'b00) || (|exec_addr[31:DEPTH_LOG2+2]);
    exec_idx = exec_addr[DEPTH_LOG2+1:2];
    // Reset on the executing edge wins: the access is aborted.
    wr_en    = exec && exec_we && !exec_err && !reset;

    if (exec) begin
      err_d   = exec_err;
      rdata_d = (!exec_err && !exec_we) ? mem[exec_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory array: not reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) begin
        if (exec_be[b]) begin
          mem[exec_idx][8*b +: 8] <= exec_wdata[8*b +: 8];
        end
      end
`else
      mem[exec_idx] <= exec_wdata;
`endif
    end
  end

`ifndef DMEM_BYTE_WRITE_EN
  // Byte enables only matter when the byte-write feature is built in.
  logic unused_be;
  assign unused_be = ^exec_be;
`endif

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, word-address width (64 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between request accept and memory access (legal range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CPU-side request present.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address (the CPU's ALU result).
REQ-009 SHALL have port req_wdata, input, 32, store data (the CPU's rt value).
REQ-010 SHALL have port rsp_valid, output, 1, response present.
REQ-011 SHALL have port rsp_ready, input, 1, CPU accepts the response.
REQ-012 SHALL have port rsp_rdata, output, 32, load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, misaligned or out-of-range access.

Function
REQ-014 SHALL implement states IDLE, WAIT and RESP.
REQ-015 In IDLE: req_ready=1, rsp_valid=0; req_valid=1 captures we/addr/wdata into internal registers and leaves IDLE.
REQ-016 From IDLE: WAIT_CYCLES>0 -> WAIT with counter=WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-017 In WAIT: req_ready=0; counter decrements each cycle; at counter=0 the access executes and the state moves to RESP.
REQ-018 Access: error = addr[1:0]!=0 or addr[31:2] >= 2**DEPTH_LOG2; an error performs no write, sets rsp_err=1 and rsp_rdata=0.
REQ-019 Legal store: writes mem[addr[DEPTH_LOG2+1:2]] on the executing edge; rsp_rdata=0.
REQ-020 Legal load: rsp_rdata = word at the captured address, registered, so it is valid together with rsp_valid.
REQ-021 In RESP: rsp_valid=1, req_ready=0; rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1, then IDLE on the next edge.
REQ-022 Accept-to-rsp_valid latency SHALL be WAIT_CYCLES+1 cycles; there is no back-to-back acceptance, so the minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-023 Requests presented while req_ready=0 SHALL be ignored and not queued.
REQ-024 A load following a store to the same address SHALL return the stored value.

Reset
REQ-025 reset=1 SHALL force IDLE, counter=0, req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0 and clear the captured registers.
REQ-026 Reset in WAIT before the executing edge SHALL abort the access with no memory write; reset in RESP SHALL drop the response.
REQ-027 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-028 Macro DMEM_BYTE_WRITE_EN: when defined, SHALL add port req_be, input, 4, byte enables; a store writes only the bytes whose req_be bit is 1 (bit0 = data[7:0]); req_be=0000 is a legal no-op store.
REQ-029 Without DMEM_BYTE_WRITE_EN, port req_be SHALL be absent and every legal store SHALL write all 32 bits.

Verification
REQ-030 Store addr 0x10, data 0xDEADBEEF, then load 0x10, rsp_ready=1 -> load rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 Load addr 0x13 -> rsp_err=1, rsp_rdata=0; load addr 0x100 (DEPTH_LOG2=6) -> rsp_err=1; a store to 0x100 leaves all words unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is ignored; rsp_ready=1 -> IDLE next cycle.
REQ-033 Store 0x55 to 0x04, then assert reset during WAIT of a store 0xAA to 0x04 -> rsp_valid=0, req_ready=1 after reset; a subsequent load of 0x04 returns 0x55.
REQ-034 WAIT_CYCLES=0 build: accept -> rsp_valid next cycle; with DMEM_BYTE_WRITE_EN, store 0xFFFFFFFF with req_be=0101 over 0 -> load returns 0x00FF00FF.
